// File: rtl/parking_sensor_fsm_if.sv
// Sensor-side bundle for the parking front end: raw beam lines in, vehicle events out.
interface parking_sensor_fsm_if;
    logic a;
    logic b;
    logic car_enter;
    logic car_exit;
    logic seq_error;
    logic busy;

    modport master (
        output a,
        output b,
        input  car_enter,
        input  car_exit,
        input  seq_error,
        input  busy
    );

    modport slave (
        input  a,
        input  b,
        output car_enter,
        output car_exit,
        output seq_error,
        output busy
    );
endinterface

// File: rtl/parking_sensor_fsm.sv
// Parking front end: synchronises and debounces the two beam sensors, then tracks
// the two-sensor passage order and emits one-cycle enter/exit/error pulses.
module parking_sensor_fsm #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_sensor_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_E1   = 3'd1,
        S_E2   = 3'd2,
        S_E3   = 3'd3,
        S_X1   = 3'd4,
        S_X2   = 3'd5,
        S_X3   = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_ENTER = 2'd1,
        EV_EXIT  = 2'd2,
        EV_ERR   = 2'd3
    } ev_t;

    localparam logic [7:0]       DB_MAX = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             a_meta_q, a_meta_d, a_sync_q, a_sync_d;
    logic             b_meta_q, b_meta_d, b_sync_q, b_sync_d;
    logic [1:0]       s_s, s_last_q, s_last_d;
    logic [7:0]       db_cnt_q, db_cnt_d, db_run_s;
    logic [1:0]       p_q, p_d;
    logic             p_upd_q, p_upd_d;
    logic             commit_s;
    state_t           state_q, state_d;
    ev_t              ev_s;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             timeout_s;
    logic             car_enter_q, car_enter_d;
    logic             car_exit_q, car_exit_d;
    logic             seq_error_q, seq_error_d;
    logic             busy_q, busy_d;

    // Synchroniser shift and debounce of the sampled pair into the committed pair p.
    always_comb begin
        a_meta_d = bus.a;
        b_meta_d = bus.b;
        a_sync_d = a_meta_q;
        b_sync_d = b_meta_q;
        s_s      = {a_sync_q, b_sync_q};
        s_last_d = s_s;
        // A fresh value restarts the run, so the count always measures one stable value.
        db_run_s = (s_s != s_last_q) ? 8'd0 : db_cnt_q;
        commit_s = 1'b0;
        p_d      = p_q;
        db_cnt_d = 8'd0;
        if (s_s != p_q) begin
            if (db_run_s == DB_MAX) begin
                commit_s = 1'b1;
                p_d      = s_s;
                db_cnt_d = 8'd0;
            end else begin
                db_cnt_d = db_run_s + 8'd1;
            end
        end else begin
            db_cnt_d = 8'd0;
        end
        p_upd_d = commit_s;
    end

    // Front-end registers: synchroniser, debounce counter, committed pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_meta_q <= 1'b0;
            b_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            b_sync_q <= 1'b0;
            s_last_q <= 2'b00;
            db_cnt_q <= 8'd0;
            p_q      <= 2'b00;
            p_upd_q  <= 1'b0;
        end else begin
            a_meta_q <= a_meta_d;
            b_meta_q <= b_meta_d;
            a_sync_q <= a_sync_d;
            b_sync_q <= b_sync_d;
            s_last_q <= s_last_d;
            db_cnt_q <= db_cnt_d;
            p_q      <= p_d;
            p_upd_q  <= p_upd_d;
        end
    end

    // Passage FSM next state and event; diagonal jumps fall into the default arms.
    always_comb begin
        state_d   = state_q;
        ev_s      = EV_NONE;
        timeout_s = (tmr_q == TO_MAX);
        case (state_q)
            S_IDLE: begin
                if (p_upd_q) begin
                    case (p_q)
                        2'b10:   state_d = S_E1;
                        2'b01:   state_d = S_X1;
                        2'b11:   begin state_d = S_ERR; ev_s = EV_ERR; end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_E1, S_E2, S_E3, S_X1, S_X2, S_X3: begin
                if (p_upd_q) begin
                    state_d = S_ERR;
                    ev_s    = EV_ERR;
                    case ({state_q, p_q})
                        {S_E1, 2'b11}: begin state_d = S_E2;   ev_s = EV_NONE;  end
                        {S_E1, 2'b00}: begin state_d = S_IDLE; ev_s = EV_NONE;  end
                        {S_E2, 2'b01}: begin state_d = S_E3;   ev_s = EV_NONE;  end
                        {S_E2, 2'b10}: begin state_d = S_E1;   ev_s = EV_NONE;  end
                        {S_E3, 2'b00}: begin state_d = S_IDLE; ev_s = EV_ENTER; end
                        {S_E3, 2'b11}: begin state_d = S_E2;   ev_s = EV_NONE;  end
                        {S_X1, 2'b11}: begin state_d = S_X2;   ev_s = EV_NONE;  end
                        {S_X1, 2'b00}: begin state_d = S_IDLE; ev_s = EV_NONE;  end
                        {S_X2, 2'b10}: begin state_d = S_X3;   ev_s = EV_NONE;  end
                        {S_X2, 2'b01}: begin state_d = S_X1;   ev_s = EV_NONE;  end
                        {S_X3, 2'b00}: begin state_d = S_IDLE; ev_s = EV_EXIT;  end
                        {S_X3, 2'b11}: begin state_d = S_X2;   ev_s = EV_NONE;  end
                        default:       begin state_d = S_ERR;  ev_s = EV_ERR;   end
                    endcase
                end else if (timeout_s) begin
                    state_d = S_ERR;
                    ev_s    = EV_ERR;
                end else begin
                    state_d = state_q;
                end
            end
            S_ERR: begin
                if (p_q == 2'b00) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stall timer only runs while a passage is in progress.
        if ((state_d != state_q) || p_upd_q || commit_s) begin
            tmr_d = '0;
        end else if ((state_q != S_IDLE) && (state_q != S_ERR)) begin
            tmr_d = tmr_q + CNT_W'(1);
        end else begin
            tmr_d = '0;
        end
    end

    // Output decode of the transition taken this cycle.
    always_comb begin
        car_enter_d = 1'b0;
        car_exit_d  = 1'b0;
        seq_error_d = 1'b0;
        case (ev_s)
            EV_ENTER: car_enter_d = 1'b1;
            EV_EXIT:  car_exit_d  = 1'b1;
            EV_ERR:   seq_error_d = 1'b1;
            default:  car_enter_d = 1'b0;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FSM state, stall timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            car_enter_q <= 1'b0;
            car_exit_q  <= 1'b0;
            seq_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            car_enter_q <= car_enter_d;
            car_exit_q  <= car_exit_d;
            seq_error_q <= seq_error_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.car_enter = car_enter_q;
    assign bus.car_exit  = car_exit_q;
    assign bus.seq_error = seq_error_q;
    assign bus.busy      = busy_q;

endmodule
